alu_ctrl_fsm: RTL and testbench
===============================

# alu_ctrl_fsm

Multi-cycle instruction controller that drives the datapath around the 32-bit ALU. Fetches a word through a ready/request memory port, decodes the 4-bit instruction opcode, issues the matching 4-bit `AluOp` and operand-select code, and sequences memory access, register write-back and PC update. It is the producer side of the `AluOp` interface. Register file, IR, PC and ALU stay in the datapath.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_ready`  in  1  memory completes the current access this cycle
- `fetch_op`  in  4  `mem_rdata[31:28]`, sampled on fetch completion
- `alu_zero`  in  1  ALU result == 0, valid in EXEC
- `mem_req`  out  1  memory access request, held until `mem_ready`
- `mem_we`  out  1  write strobe, qualifies `mem_req`
- `addr_sel`  out  1  0 = PC, 1 = ALU result
- `ir_load`  out  1  load IR from `mem_rdata`
- `pc_write`  out  1  update PC this cycle
- `pc_src`  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- `alu_op`  out  4  ALU opcode
- `alu_b_sel`  out  2  0 = rt register, 1 = sign-extended imm16, 2 = zero-extended imm16
- `reg_write`  out  1  register-file write enable
- `wb_sel`  out  1  0 = ALU result, 1 = memory data
- `halted`  out  1  HALT executed

## Operation
- Instruction opcode map. In the R-type group, `alu_op` = opcode and `b_sel` = 0:
  - 0x0 AND, 0x1 OR, 0x2 XOR, 0x3 NOT, 0x4 ADD, 0x5 SUB, 0x6 SLT
  - 0x7 ADDI: `alu_op` 0100, `b_sel` 1
  - 0x8 LW and 0x9 SW: `alu_op` 0100, `b_sel` 1
  - 0xA SHLI: `alu_op` 1010, `b_sel` 2
  - 0xB SHRI: `alu_op` 1011, `b_sel` 2
  - 0xC BEQ: `alu_op` 0101, `b_sel` 0
  - 0xD LUI: `alu_op` 1101, `b_sel` 2
  - 0xE JMP and 0xF HALT: `alu_op` 0000
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: entered on reset. All outputs 0. Goes to FETCH unconditionally on the next edge.
- FETCH: `mem_req`=1, `addr_sel`=0, `mem_we`=0.
  - When `mem_ready`=1: `ir_load`=1, `pc_write`=1, `pc_src`=0, latch `fetch_op` into the internal opcode register, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, no strobes. The datapath reads registers. Go to EXEC.
- EXEC: `alu_op` and `alu_b_sel` are driven from the latched opcode.
  - ALU and immediate ops (0x0–0x7, 0xA, 0xB, 0xD) go to WB.
  - LW and SW go to MEM.
  - BEQ: `pc_write` = `alu_zero`, `pc_src`=1, then FETCH.
  - JMP: `pc_write`=1, `pc_src`=2, then FETCH.
  - HALT goes to HALT.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we` = (op==SW). `alu_op` is held at ADD so the address stays stable.
  - On `mem_ready`: LW goes to WB, SW goes to FETCH.
- WB: `reg_write`=1, `wb_sel` = (op==LW), then FETCH.
- HALT: `halted`=1 and all other strobes are 0. The FSM stays here until reset.
- Outputs are a function of state and latched opcode (Moore), except these, which are Mealy:
  - `ir_load` and FETCH `pc_write` on `mem_ready`
  - BEQ `pc_write` on `alu_zero`
- Every opcode is legal. No error state exists.

## Timing
- Reset values: state IDLE, opcode register 0x0, every output 0.
- Reset assertion at any time, including mid-FETCH or mid-MEM with `mem_req` high, forces IDLE asynchronously. `mem_req` drops immediately.
- Cycles per instruction with zero-wait memory (`mem_ready` high on the first request cycle):
  - ALU and immediate ops: 4
  - LW: 5
  - SW: 4
  - BEQ and JMP: 3
- Each memory wait cycle adds 1 cycle.
- `mem_req` is never deasserted before `mem_ready` while in FETCH or MEM.
- `mem_ready` outside FETCH and MEM is ignored.
- Exactly one `pc_write` pulse during FETCH. At most one more in EXEC (BEQ taken or JMP).
- `reg_write` is exactly one cycle per write-back instruction. It is never asserted for SW, BEQ, JMP or HALT.

## Structure
- Shared package `pierogi_pkg` holds:
  - ALU opcode constants (AND…LUI)
  - instruction opcode constants
  - state enum
  - `pc_src` encodings
  - `alu_b_sel` encodings
- Sub-module `alu_op_decode`: purely combinational, maps the 4-bit instruction opcode to {`alu_op`, `alu_b_sel`, is_mem, is_store, is_branch, is_jump, is_halt, writes_reg}. The FSM instantiates it once.

## Test plan
- Reset, then ADD (0x4) with `mem_ready` tied high:
  - IDLE→FETCH→DECODE→EXEC→WB
  - `alu_op`=0100 in EXEC
  - `reg_write` pulses in cycle 4 after FETCH entry
  - exactly one `pc_write` with `pc_src`=0
- LW with 2 fetch wait cycles and 3 MEM wait cycles:
  - `mem_req` held continuously
  - in MEM: `addr_sel`=1, `mem_we`=0
  - WB has `wb_sel`=1
  - total 10 cycles
- BEQ:
  - `alu_zero`=1 → EXEC `pc_write`=1, `pc_src`=1
  - `alu_zero`=0 → no EXEC `pc_write`
  - both return to FETCH in 3 cycles
- SW then JMP:
  - SW: `mem_we`=1 only in MEM, no `reg_write`
  - JMP: `pc_src`=2, `pc_write`=1 in EXEC
- HALT: `halted`=1 and stays set while `mem_ready` toggles. `rst_n` low clears it and all outputs asynchronously; release resumes at IDLE.
- Sweep all 16 opcodes: in EXEC, `alu_op` and `alu_b_sel` match the opcode map exactly, including SHLI→1010/2 and LUI→1101/2.

Source files
------------

// File: rtl/pierogi_pkg.sv
// Shared definitions for the instruction controller: ALU and instruction
// opcodes, controller state encoding and datapath select encodings.
package pierogi_pkg;

  // ALU operation codes understood by the datapath ALU
  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_XOR = 4'h2;
  localparam logic [3:0] ALU_NOT = 4'h3;
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [3:0] ALU_SUB = 4'h5;
  localparam logic [3:0] ALU_SLT = 4'h6;
  localparam logic [3:0] ALU_SHL = 4'hA;
  localparam logic [3:0] ALU_SHR = 4'hB;
  localparam logic [3:0] ALU_LUI = 4'hD;

  // Instruction opcodes taken from mem_rdata[31:28]
  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_SHLI = 4'hA;
  localparam logic [3:0] OP_SHRI = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_LUI  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // ALU B-operand select
  localparam logic [1:0] BSEL_RT   = 2'd0;
  localparam logic [1:0] BSEL_SIMM = 2'd1;
  localparam logic [1:0] BSEL_ZIMM = 2'd2;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decoder: maps a 4-bit instruction opcode to the
// ALU operation, B-operand select and the instruction class flags that steer
// the controller's sequencing.
module alu_op_decode
  import pierogi_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [3:0] alu_op,
  output logic [1:0] alu_b_sel,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_halt,
  output logic       writes_reg
);

  // Opcode map; every opcode is legal so each one has an explicit entry
  always_comb begin
    alu_op     = ALU_AND;
    alu_b_sel  = BSEL_RT;
    is_mem     = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_halt    = 1'b0;
    writes_reg = 1'b0;
    case (opcode)
      OP_AND: begin
        alu_op     = ALU_AND;
        writes_reg = 1'b1;
      end
      OP_OR: begin
        alu_op     = ALU_OR;
        writes_reg = 1'b1;
      end
      OP_XOR: begin
        alu_op     = ALU_XOR;
        writes_reg = 1'b1;
      end
      OP_NOT: begin
        alu_op     = ALU_NOT;
        writes_reg = 1'b1;
      end
      OP_ADD: begin
        alu_op     = ALU_ADD;
        writes_reg = 1'b1;
      end
      OP_SUB: begin
        alu_op     = ALU_SUB;
        writes_reg = 1'b1;
      end
      OP_SLT: begin
        alu_op     = ALU_SLT;
        writes_reg = 1'b1;
      end
      OP_ADDI: begin
        alu_op     = ALU_ADD;
        alu_b_sel  = BSEL_SIMM;
        writes_reg = 1'b1;
      end
      OP_LW: begin
        alu_op     = ALU_ADD;
        alu_b_sel  = BSEL_SIMM;
        is_mem     = 1'b1;
        writes_reg = 1'b1;
      end
      OP_SW: begin
        alu_op    = ALU_ADD;
        alu_b_sel = BSEL_SIMM;
        is_mem    = 1'b1;
        is_store  = 1'b1;
      end
      OP_SHLI: begin
        alu_op     = ALU_SHL;
        alu_b_sel  = BSEL_ZIMM;
        writes_reg = 1'b1;
      end
      OP_SHRI: begin
        alu_op     = ALU_SHR;
        alu_b_sel  = BSEL_ZIMM;
        writes_reg = 1'b1;
      end
      OP_BEQ: begin
        alu_op    = ALU_SUB;
        alu_b_sel = BSEL_RT;
        is_branch = 1'b1;
      end
      OP_LUI: begin
        alu_op     = ALU_LUI;
        alu_b_sel  = BSEL_ZIMM;
        writes_reg = 1'b1;
      end
      OP_JMP: begin
        alu_op  = ALU_AND;
        is_jump = 1'b1;
      end
      OP_HALT: begin
        alu_op  = ALU_AND;
        is_halt = 1'b1;
      end
      default: begin
        alu_op = ALU_AND;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle instruction controller around the 32-bit ALU datapath.
// Sequences fetch, decode, execute, memory access and write-back. Most outputs
// are registered Moore outputs computed for the state being entered; ir_load
// and pc_write are Mealy so they can react to mem_ready / alu_zero in-cycle.
module alu_ctrl_fsm
  import pierogi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_ready,
  input  logic [3:0] fetch_op,
  input  logic       alu_zero,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic [1:0] alu_b_sel,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       halted
);

  state_t     state;
  logic [3:0] op_reg;

  logic [3:0] dec_alu_op;
  logic [1:0] dec_b_sel;
  logic       dec_is_mem;
  logic       dec_is_store;
  logic       dec_is_branch;
  logic       dec_is_jump;
  logic       dec_is_halt;
  logic       dec_writes_reg;

  // The decoder always looks at the latched opcode, which is stable from
  // DECODE until the next fetch completes.
  alu_op_decode u_decode (
    .opcode     (op_reg),
    .alu_op     (dec_alu_op),
    .alu_b_sel  (dec_b_sel),
    .is_mem     (dec_is_mem),
    .is_store   (dec_is_store),
    .is_branch  (dec_is_branch),
    .is_jump    (dec_is_jump),
    .is_halt    (dec_is_halt),
    .writes_reg (dec_writes_reg)
  );

  // Mealy strobes: IR load and PC update on fetch completion, plus the EXEC PC update for taken BEQ or JMP
  always_comb begin
    ir_load  = (state == ST_FETCH) && mem_ready;
    pc_write = ((state == ST_FETCH) && mem_ready) ||
               ((state == ST_EXEC) && (dec_is_jump || (dec_is_branch && alu_zero)));
  end

  // State register, opcode latch and registered Moore outputs for the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_reg    <= OP_AND;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      addr_sel  <= 1'b0;
      pc_src    <= PC_SRC_SEQ;
      alu_op    <= ALU_AND;
      alu_b_sel <= BSEL_RT;
      reg_write <= 1'b0;
      wb_sel    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      addr_sel  <= 1'b0;
      pc_src    <= PC_SRC_SEQ;
      alu_op    <= ALU_AND;
      alu_b_sel <= BSEL_RT;
      reg_write <= 1'b0;
      wb_sel    <= 1'b0;
      halted    <= 1'b0;
      case (state)
        ST_IDLE: begin
          state   <= ST_FETCH;
          mem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (mem_ready) begin
            op_reg <= fetch_op;
            state  <= ST_DECODE;
          end else begin
            state   <= ST_FETCH;
            mem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          state     <= ST_EXEC;
          alu_op    <= dec_alu_op;
          alu_b_sel <= dec_b_sel;
          if (dec_is_branch) begin
            pc_src <= PC_SRC_BRANCH;
          end else if (dec_is_jump) begin
            pc_src <= PC_SRC_JUMP;
          end else begin
            pc_src <= PC_SRC_SEQ;
          end
        end
        ST_EXEC: begin
          if (dec_is_halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (dec_is_mem) begin
            state    <= ST_MEM;
            mem_req  <= 1'b1;
            addr_sel <= 1'b1;
            mem_we   <= dec_is_store;
            alu_op   <= ALU_ADD;
          end else if (dec_is_branch || dec_is_jump) begin
            state   <= ST_FETCH;
            mem_req <= 1'b1;
          end else if (dec_writes_reg) begin
            state     <= ST_WB;
            reg_write <= 1'b1;
            wb_sel    <= 1'b0;
          end else begin
            state   <= ST_FETCH;
            mem_req <= 1'b1;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (dec_is_store) begin
              state   <= ST_FETCH;
              mem_req <= 1'b1;
            end else begin
              state     <= ST_WB;
              reg_write <= 1'b1;
              wb_sel    <= 1'b1;
            end
          end else begin
            state    <= ST_MEM;
            mem_req  <= 1'b1;
            addr_sel <= 1'b1;
            mem_we   <= dec_is_store;
            alu_op   <= ALU_ADD;
          end
        end
        ST_WB: begin
          state   <= ST_FETCH;
          mem_req <= 1'b1;
        end
        ST_HALT: begin
          state  <= ST_HALT;
          halted <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: opcode table sweep, hand-written
// multi-cycle sequences, asynchronous reset cases and a randomized
// instruction stream checked against an instruction-level reference model.
module tb_alu_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic       mem_ready;
  logic [3:0] fetch_op;
  logic       alu_zero;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       ir_load;
  logic       pc_write;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic [1:0] alu_b_sel;
  logic       reg_write;
  logic       wb_sel;
  logic       halted;
  logic [15:0] outs;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] op;
    logic [3:0] alu;
    logic [1:0] bsel;
    int         cycles;
  } vec_t;

  vec_t vecs[16];

  alu_ctrl_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_ready (mem_ready),
    .fetch_op  (fetch_op),
    .alu_zero  (alu_zero),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .alu_op    (alu_op),
    .alu_b_sel (alu_b_sel),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .halted    (halted)
  );

  assign outs = {mem_req, mem_we, addr_sel, ir_load, pc_write, pc_src,
                 alu_op, alu_b_sel, reg_write, wb_sel, halted};

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference ALU mapping straight from the opcode table
  function automatic void refMap(input logic [3:0] op, output logic [3:0] a, output logic [1:0] b);
    if (op <= 4'h6) begin
      a = op;
      b = 2'd0;
    end else if (op == 4'h7 || op == 4'h8 || op == 4'h9) begin
      a = 4'h4;
      b = 2'd1;
    end else if (op == 4'hA || op == 4'hB || op == 4'hD) begin
      a = op;
      b = 2'd2;
    end else if (op == 4'hC) begin
      a = 4'h5;
      b = 2'd0;
    end else begin
      a = 4'h0;
      b = 2'd0;
    end
  endfunction

  // Reference cycle count: base CPI plus every memory wait cycle
  function automatic int refCycles(input logic [3:0] op, input int fw, input int mw);
    int base;
    if (op == 4'hC || op == 4'hE || op == 4'hF) base = 3;
    else if (op == 4'h8) base = 5;
    else base = 4;
    return base + fw + ((op == 4'h8 || op == 4'h9) ? mw : 0);
  endfunction

  task automatic applyReset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    fetch_op  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", int'(outs), 0);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    fetch_op  = 4'h4;
    @(negedge clk);
    checkOutput("idle_outputs", int'(outs), 0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
  endtask

  // Runs one instruction starting in the first FETCH cycle and checks it
  task automatic applyStimulus(input logic [3:0] op, input int fw, input int mw, input logic zero,
                               input logic [3:0] exp_alu, input logic [1:0] exp_bsel,
                               input int exp_cycles);
    bit is_lw   = (op == 4'h8);
    bit is_sw   = (op == 4'h9);
    bit is_mem  = is_lw || is_sw;
    bit is_beq  = (op == 4'hC);
    bit is_jmp  = (op == 4'hE);
    bit is_halt = (op == 4'hF);
    bit writes  = !(is_sw || is_beq || is_jmp || is_halt);
    int exec_cyc = fw + 2;
    int mem_lo   = fw + 3;
    int mem_hi   = fw + 3 + mw;
    int irl_cnt = 0, pcw_cnt = 0, rw_cnt = 0, rw_at = -1, wbs_at_rw = 0;
    int mwe_total = 0, mwe_in_mem = 0, asel_cnt = 0, halt_cnt = 0;
    int fetch_ok = 0, ex_alu = 0, ex_bsel = 0, ex_pcw = 0, ex_pcsrc = 0;
    bit in_fetch, in_mem;
    for (int cyc = 0; cyc < exp_cycles; cyc++) begin
      in_fetch = (cyc <= fw);
      in_mem   = is_mem && (cyc >= mem_lo) && (cyc <= mem_hi);
      fetch_op = 4'($urandom_range(0, 15));
      if (in_fetch) begin
        mem_ready = (cyc == fw);
        if (cyc == fw) fetch_op = op;
      end else if (in_mem) begin
        mem_ready = (cyc == mem_hi);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      alu_zero = (cyc == exec_cyc) ? zero : 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("mem_req_cycle", int'(mem_req), int'(in_fetch || in_mem));
      if (ir_load) irl_cnt++;
      if (pc_write) pcw_cnt++;
      if (cyc == fw && ir_load && pc_write && pc_src == 2'd0) fetch_ok = 1;
      if (reg_write) begin
        rw_cnt++;
        rw_at = cyc;
        wbs_at_rw = int'(wb_sel);
      end
      if (mem_we) begin
        mwe_total++;
        if (in_mem) mwe_in_mem++;
      end
      if (addr_sel && in_mem) asel_cnt++;
      if (halted) halt_cnt++;
      if (cyc == exec_cyc) begin
        ex_alu   = int'(alu_op);
        ex_bsel  = int'(alu_b_sel);
        ex_pcw   = int'(pc_write);
        ex_pcsrc = int'(pc_src);
      end
      @(posedge clk);
      #1;
    end
    checkOutput("exec_alu_op", ex_alu, int'(exp_alu));
    checkOutput("exec_alu_b_sel", ex_bsel, int'(exp_bsel));
    checkOutput("fetch_ir_load_pc_write", fetch_ok, 1);
    checkOutput("ir_load_count", irl_cnt, 1);
    checkOutput("pc_write_count", pcw_cnt, 1 + int'(is_jmp || (is_beq && zero)));
    checkOutput("exec_pc_write", ex_pcw, int'(is_jmp || (is_beq && zero)));
    if (is_beq || is_jmp) checkOutput("exec_pc_src", ex_pcsrc, is_jmp ? 2 : 1);
    checkOutput("reg_write_count", rw_cnt, int'(writes));
    if (writes) begin
      checkOutput("reg_write_cycle", rw_at, exp_cycles - 1);
      checkOutput("wb_sel", wbs_at_rw, int'(is_lw));
    end
    checkOutput("mem_we_count", mwe_total, is_sw ? mw + 1 : 0);
    checkOutput("mem_we_in_mem", mwe_in_mem, is_sw ? mw + 1 : 0);
    checkOutput("mem_addr_sel", asel_cnt, is_mem ? mw + 1 : 0);
    checkOutput("halted_early", halt_cnt, 0);
    if (is_halt) begin
      for (int k = 0; k < 5; k++) begin
        mem_ready = 1'(k % 2);
        fetch_op  = 4'($urandom_range(0, 15));
        @(negedge clk);
        checkOutput("halted_sticky", int'(halted), 1);
        checkOutput("halt_quiet", int'({mem_req, mem_we, ir_load, pc_write, reg_write}), 0);
        @(posedge clk);
        #1;
      end
    end
  endtask

  logic [3:0] r_op;
  logic [3:0] r_alu;
  logic [1:0] r_bsel;
  int         r_fw;
  int         r_mw;

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0]  = '{4'h0, 4'h0, 2'd0, 4};
    vecs[1]  = '{4'h1, 4'h1, 2'd0, 4};
    vecs[2]  = '{4'h2, 4'h2, 2'd0, 4};
    vecs[3]  = '{4'h3, 4'h3, 2'd0, 4};
    vecs[4]  = '{4'h4, 4'h4, 2'd0, 4};
    vecs[5]  = '{4'h5, 4'h5, 2'd0, 4};
    vecs[6]  = '{4'h6, 4'h6, 2'd0, 4};
    vecs[7]  = '{4'h7, 4'h4, 2'd1, 4};
    vecs[8]  = '{4'h8, 4'h4, 2'd1, 5};
    vecs[9]  = '{4'h9, 4'h4, 2'd1, 4};
    vecs[10] = '{4'hA, 4'hA, 2'd2, 4};
    vecs[11] = '{4'hB, 4'hB, 2'd2, 4};
    vecs[12] = '{4'hC, 4'h5, 2'd0, 3};
    vecs[13] = '{4'hD, 4'hD, 2'd2, 4};
    vecs[14] = '{4'hE, 4'h0, 2'd0, 3};
    vecs[15] = '{4'hF, 4'h0, 2'd0, 3};

    applyReset();

    // ADD with zero-wait memory, then LW with fetch and memory waits
    applyStimulus(4'h4, 0, 0, 1'b0, 4'h4, 2'd0, 4);
    applyStimulus(4'h8, 2, 3, 1'b0, 4'h4, 2'd1, 10);

    // BEQ taken and not taken, then SW followed by JMP
    applyStimulus(4'hC, 0, 0, 1'b1, 4'h5, 2'd0, 3);
    applyStimulus(4'hC, 0, 0, 1'b0, 4'h5, 2'd0, 3);
    applyStimulus(4'h9, 1, 2, 1'b0, 4'h4, 2'd1, 7);
    applyStimulus(4'hE, 0, 0, 1'b0, 4'h0, 2'd0, 3);

    // Opcode table sweep, ending in HALT
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, 0, 0, 1'(i % 2), vecs[i].alu, vecs[i].bsel, vecs[i].cycles);
    end

    // Reset out of HALT is asynchronous
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_halt", int'(outs), 0);
    applyReset();

    // Reset in the middle of a stalled fetch
    mem_ready = 1'b0;
    #2;
    checkOutput("fetch_req_before_reset", int'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_fetch", int'(outs), 0);
    applyReset();

    // Reset in the middle of a stalled LW memory access
    mem_ready = 1'b1;
    fetch_op  = 4'h8;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checkOutput("mem_req_addr_sel", int'({mem_req, addr_sel}), 3);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_mem", int'(outs), 0);
    applyReset();

    // Randomized instruction stream against the reference model
    for (int i = 0; i < 60; i++) begin
      r_op = 4'($urandom_range(0, 14));
      r_fw = $urandom_range(0, 3);
      r_mw = $urandom_range(0, 3);
      refMap(r_op, r_alu, r_bsel);
      applyStimulus(r_op, r_fw, r_mw, 1'($urandom_range(0, 1)), r_alu, r_bsel,
                    refCycles(r_op, r_fw, r_mw));
    end
    r_fw = $urandom_range(0, 3);
    refMap(4'hF, r_alu, r_bsel);
    applyStimulus(4'hF, r_fw, 0, 1'b0, r_alu, r_bsel, refCycles(4'hF, r_fw, 0));
    applyReset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
